// File: rtl/bit_deserializer.sv
// Serial-to-parallel front end: assembles WORD_W-bit words from a 1-bit valid/ready
// stream into a one-word holding register. Define BIT_DESERIALIZER_MSB_FIRST_EN for MSB-first order.
module bit_deserializer #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic              bit_ready,
    input  logic              sync,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  fill
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] base;
    logic [WORD_W-1:0] shifted;
    logic              last;
    logic              accept;
    logic              complete;

    // Both ports transfer on valid && ready at a rising edge; valid never waits on ready.
    // Only the final bit of a word stalls, and only while the holding register
    // is full and not being drained in the same cycle.
    assign last      = (fill == LAST);
    assign bit_ready = !(last && word_valid && !word_ready);
    assign accept    = bit_valid && bit_ready;
    assign complete  = accept && last && !sync;

    // sync drops the partial word, so the accepted bit shifts into an empty register.
    assign base = sync ? '0 : shreg;

`ifdef BIT_DESERIALIZER_MSB_FIRST_EN
    assign shifted = {base[WORD_W-2:0], bit_in};
`else
    assign shifted = {bit_in, base[WORD_W-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg      <= '0;
            fill       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (complete) begin
                    shreg <= '0;
                    fill  <= '0;
                end else begin
                    shreg <= shifted;
                    fill  <= sync ? CNT_W'(1) : fill + CNT_W'(1);
                end
            end else if (sync) begin
                shreg <= '0;
                fill  <= '0;
            end

            // A completing word may replace one being drained at the same edge.
            if (complete) begin
                word_out   <= shifted;
                word_valid <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Self-checking bench for bit_deserializer: directed scenarios plus random traffic,
// compared every cycle against a bit-queue / word-queue reference model.
module tb_bit_deserializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

`ifdef BIT_DESERIALIZER_MSB_FIRST_EN
    localparam logic [W-1:0] T1_WORD = 8'h0F;
    localparam logic [W-1:0] A_WORD  = 8'hE0;
    localparam logic [W-1:0] B_WORD  = 8'hE4;
    localparam logic [W-1:0] T4_WORD = 8'h80;
    localparam logic [W-1:0] T6_WORD = 8'hF0;
`else
    localparam logic [W-1:0] T1_WORD = 8'hF0;
    localparam logic [W-1:0] A_WORD  = 8'h07;
    localparam logic [W-1:0] B_WORD  = 8'h27;
    localparam logic [W-1:0] T4_WORD = 8'h01;
    localparam logic [W-1:0] T6_WORD = 8'h0F;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_in;
    logic          bit_valid;
    logic          bit_ready;
    logic          sync;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          word_ready;
    logic [CW-1:0] fill;

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the current partial word in arrival order, and
    // completed words not yet taken by the consumer.
    bit           part_q[$];
    logic [W-1:0] exp_q[$];

    bit_deserializer #(.WORD_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .sync       (sync),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .fill       (fill)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] pack_word();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < W; k++) begin
`ifdef BIT_DESERIALIZER_MSB_FIRST_EN
            w[W-1-k] = part_q[k];
`else
            w[k] = part_q[k];
`endif
        end
        return w;
    endfunction

    // Driver: one clock cycle of stimulus, model update and output checks.
    task automatic drive_cycle(input logic v, input logic b, input logic s, input logic r);
        logic exp_rdy;
        logic acc;
        @(negedge clk);
        bit_valid  = v;
        bit_in     = b;
        sync       = s;
        word_ready = r;
        #1;
        exp_rdy = !(part_q.size() == W - 1 && exp_q.size() != 0 && !r);
        check("bit_ready", {31'd0, bit_ready}, {31'd0, exp_rdy});
        acc = v && exp_rdy;
        @(posedge clk);
        if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
        if (s) part_q.delete();
        if (acc) begin
            part_q.push_back(b);
            if (part_q.size() == W) begin
                exp_q.push_back(pack_word());
                part_q.delete();
            end
        end
        #1;
        check("fill", 32'(fill), 32'(part_q.size()));
        check("word_valid", {31'd0, word_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) check("word_out", 32'(word_out), 32'(exp_q[0]));
    endtask

    // seq[k] is the k-th bit sent.
    task automatic send_word(input logic [W-1:0] seq, input logic r);
        for (int k = 0; k < W; k++) drive_cycle(1'b1, seq[k], 1'b0, r);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n      = 1'b0;
        bit_valid  = 1'b0;
        sync       = 1'b0;
        word_ready = 1'b0;
        #1;
        check("rst_word_valid", {31'd0, word_valid}, 32'd0);
        check("rst_word_out", 32'(word_out), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_bit_ready", {31'd0, bit_ready}, 32'd1);
        part_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        sync       = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_fill", 32'(fill), 32'd0);
        check("init_word_valid", {31'd0, word_valid}, 32'd0);
        check("init_word_out", 32'(word_out), 32'd0);
        check("init_bit_ready", {31'd0, bit_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic word
        send_word(8'hF0, 1'b1);
        check("t1_word_out", 32'(word_out), 32'(T1_WORD));
        check("t1_word_valid", {31'd0, word_valid}, 32'd1);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_valid_one_cycle", {31'd0, word_valid}, 32'd0);

        // Backpressure: final bit of B stalls until A drains
        send_word(8'h07, 1'b0);
        check("t2_word_a", 32'(word_out), 32'(A_WORD));
        for (int k = 0; k < W - 1; k++) drive_cycle(1'b1, B_SEQ(k), 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_stall_fill", 32'(fill), 32'(W - 1));
        check("t2_stall_word", 32'(word_out), 32'(A_WORD));
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t2_word_b", 32'(word_out), 32'(B_WORD));
        check("t2_fill_zero", 32'(fill), 32'd0);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Simultaneous drain and complete
        send_word(8'h00, 1'b1);
        send_word(8'hFF, 1'b1);
        check("t3_word_ff", 32'(word_out), 32'hFF);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // sync with and without an accept
        for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_sync_fill", 32'(fill), 32'd1);
        for (int k = 0; k < W - 1; k++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        check("t4_word", 32'(word_out), 32'(T4_WORD));
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        check("t4_sync_clear", 32'(fill), 32'd0);
        check("t4_no_word", {31'd0, word_valid}, 32'd0);

        // Async reset mid-word with a word held
        send_word(8'h5A, 1'b0);
        for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_pre_fill", 32'(fill), 32'd4);
        async_reset();
        for (int k = 0; k < W - 1; k++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_no_early_word", {31'd0, word_valid}, 32'd0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("t5_fresh_word", 32'(word_out), 32'hFF);
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Bit order
        send_word(8'h0F, 1'b1);
        check("t6_order", 32'(word_out), 32'(T6_WORD));

        // Random traffic with alternating backpressure phases
        for (int n = 0; n < 3000; n++) begin
            logic r;
            if ((n / 200) % 2 == 0) r = ($urandom_range(0, 3) != 0);
            else                    r = ($urandom_range(0, 4) == 0);
            drive_cycle(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 15) == 0), r);
            if (n == 1500) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic B_SEQ(input int k);
        logic [W-1:0] seq;
        seq = 8'h27;
        return seq[k];
    endfunction

endmodule
